matrix2x2_operand_loader: RTL and testbench

Upstream feeder for the 2x2 matrix multiplier.
- Accepts a byte-serial stream of matrix elements over a valid/ready handshake.
- Assembles two 2x2 operand matrices, A and B, each packed as four 8-bit elements in one 32-bit word.
- Presents A and B as a stable frame on out_a/out_b with a valid/ack handshake.
- Has one staging buffer, so the next frame can load while the current frame waits for the multiplier.

---
 rtl/matrix2x2_operand_loader.sv | 92 +++++++++
 tb/tb_matrix2x2_operand_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix2x2_operand_loader.sv
// Byte-serial loader that assembles two packed 2x2 operand matrices (A, B)
// and hands them to the multiplier through a single staging buffer.
module matrix2x2_operand_loader #(
  parameter int ELEM_W      = 8,
  parameter int B_COL_MAJOR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ELEM_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*ELEM_W-1:0] out_a,
  output logic [4*ELEM_W-1:0] out_b,
  output logic                out_valid,
  input  logic                out_ack,
  output logic [7:0]          frame_cnt
);

  localparam int WORD_W = 4 * ELEM_W;

  logic [2:0]        elem_cnt;
  logic              stage_full;
  logic [WORD_W-1:0] stage_a;
  logic [WORD_W-1:0] stage_b;

  logic              accept;
  logic              transfer;
  logic              take;
  logic [1:0]        slot;
  logic [1:0]        pos;
  logic [WORD_W-1:0] cur_word;
  logic [WORD_W-1:0] merged;

  assign in_ready = !stage_full;

  // Column-major B swaps the middle two slots, so the word is always row-major.
  always_comb begin
    accept   = in_valid && !stage_full;
    transfer = stage_full && (!out_valid || out_ack);
    take     = out_valid && out_ack;
    slot     = elem_cnt[1:0];
    pos      = (elem_cnt[2] && (B_COL_MAJOR != 0)) ? {slot[0], slot[1]} : slot;
    cur_word = elem_cnt[2] ? stage_b : stage_a;
    merged   = cur_word;
    case (pos)
      2'd0:    merged[WORD_W-1   -: ELEM_W] = in_data;
      2'd1:    merged[3*ELEM_W-1 -: ELEM_W] = in_data;
      2'd2:    merged[2*ELEM_W-1 -: ELEM_W] = in_data;
      default: merged[ELEM_W-1   -: ELEM_W] = in_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      elem_cnt   <= 3'd0;
      stage_full <= 1'b0;
      stage_a    <= '0;
      stage_b    <= '0;
      out_a      <= '0;
      out_b      <= '0;
      out_valid  <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      if (accept) begin
        if (elem_cnt[2]) begin
          stage_b <= merged;
        end else begin
          stage_a <= merged;
        end
        elem_cnt <= elem_cnt + 3'd1;
        if (elem_cnt == 3'd7) begin
          stage_full <= 1'b1;
        end
      end

      // Accept and transfer are mutually exclusive since accept needs an empty stage.
      if (transfer) begin
        out_a      <= stage_a;
        out_b      <= stage_b;
        out_valid  <= 1'b1;
        stage_full <= 1'b0;
      end else if (take) begin
        out_valid <= 1'b0;
      end

      if (take) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_matrix2x2_operand_loader.sv
// Scoreboard bench for matrix2x2_operand_loader: row-major and column-major
// instances share one stimulus stream; a monitor checks every handshake.
module tb_matrix2x2_operand_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ack;

  logic        in_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_valid;
  logic [7:0]  frame_cnt;

  logic        cm_in_ready;
  logic [31:0] cm_out_a;
  logic [31:0] cm_out_b;
  logic        cm_out_valid;
  logic [7:0]  cm_frame_cnt;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b_row;
    logic [31:0] b_col;
  } frame_t;

  frame_t     sb[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] elems[8];
  int         n_elems = 0;
  logic [7:0] model_cnt = 8'd0;

  always #5 clk = ~clk;

  matrix2x2_operand_loader #(.ELEM_W(8), .B_COL_MAJOR(0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_a(out_a), .out_b(out_b),
    .out_valid(out_valid), .out_ack(out_ack), .frame_cnt(frame_cnt)
  );

  matrix2x2_operand_loader #(.ELEM_W(8), .B_COL_MAJOR(1)) dut_cm (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(cm_in_ready), .out_a(cm_out_a), .out_b(cm_out_b),
    .out_valid(cm_out_valid), .out_ack(out_ack), .frame_cnt(cm_frame_cnt)
  );

  task automatic record_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one element and wait (bounded) until it is accepted; called at a negedge.
  task automatic apply_stimulus(input logic [7:0] d);
    int waits = 0;
    frame_t f;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      record_fail("accept_timeout");
    end else begin
      @(posedge clk);
      elems[n_elems] = d;
      n_elems++;
      if (n_elems == 8) begin
        f.a     = {elems[0], elems[1], elems[2], elems[3]};
        f.b_row = {elems[4], elems[5], elems[6], elems[7]};
        f.b_col = {elems[4], elems[6], elems[5], elems[7]};
        sb.push_back(f);
        n_elems = 0;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(base + 8'(i));
      if (gaps) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) record_fail(name);
  endtask

  task automatic ack_frame();
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
  endtask

  // Monitor: every handshake must deliver the oldest expected frame.
  always @(negedge clk) begin : monitor
    frame_t f;
    #2;
    if (!rst) begin
      model_cnt = 8'd0;
    end else if (out_valid && out_ack) begin
      if (sb.size() == 0) begin
        record_fail("sb_underflow");
      end else begin
        f = sb.pop_front();
        check_output("frame_a", out_a, f.a);
        check_output("frame_b", out_b, f.b_row);
        check_output("cm_frame_a", cm_out_a, f.a);
        check_output("cm_frame_b", cm_out_b, f.b_col);
      end
      check_output("handshake_cnt", {24'd0, frame_cnt}, {24'd0, model_cnt});
      check_output("cm_valid_match", {31'd0, cm_out_valid}, 32'd1);
      model_cnt = model_cnt + 8'd1;
    end
  end

  initial begin
    rst      = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    out_ack  = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_out_a", out_a, 32'h0);
    check_output("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    rst = 1'b1;

    // Basic load and two-edge latency
    send_frame(8'h01, 1'b0);
    check_output("latency_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_output("latency_valid", {31'd0, out_valid}, 32'd1);
    check_output("basic_a", out_a, 32'h01020304);
    check_output("basic_b", out_b, 32'h05060708);
    check_output("cm_basic_a", cm_out_a, 32'h01020304);
    check_output("cm_basic_b", cm_out_b, 32'h05070608);
    check_output("basic_cnt", {24'd0, frame_cnt}, 32'd0);
    ack_frame();
    check_output("ack_drop_valid", {31'd0, out_valid}, 32'd0);
    check_output("ack_keep_a", out_a, 32'h01020304);
    check_output("ack_cnt", {24'd0, frame_cnt}, 32'd1);

    // Ack with nothing valid is ignored
    ack_frame();
    check_output("idle_ack_cnt", {24'd0, frame_cnt}, 32'd1);
    check_output("idle_ack_valid", {31'd0, out_valid}, 32'd0);

    // Gaps between elements do not change packing
    send_frame(8'h21, 1'b1);
    wait_valid("gap_wait");
    check_output("gap_a", out_a, 32'h21222324);
    check_output("gap_b", out_b, 32'h25262728);
    check_output("cm_gap_b", cm_out_b, 32'h25272628);
    ack_frame();
    check_output("gap_cnt", {24'd0, frame_cnt}, 32'd2);

    // Backpressure, then ack coinciding with transfer
    send_frame(8'h01, 1'b0);
    send_frame(8'h11, 1'b0);
    check_output("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("bp_valid", {31'd0, out_valid}, 32'd1);
    check_output("bp_a", out_a, 32'h01020304);
    repeat (3) @(negedge clk);
    check_output("bp_hold_a", out_a, 32'h01020304);
    check_output("bp_hold_b", out_b, 32'h05060708);
    check_output("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    ack_frame();
    check_output("swap_valid", {31'd0, out_valid}, 32'd1);
    check_output("swap_a", out_a, 32'h11121314);
    check_output("swap_b", out_b, 32'h15161718);
    check_output("cm_swap_b", cm_out_b, 32'h15171618);
    check_output("swap_cnt", {24'd0, frame_cnt}, 32'd3);
    check_output("swap_in_ready", {31'd0, in_ready}, 32'd1);
    ack_frame();
    check_output("swap_ack_cnt", {24'd0, frame_cnt}, 32'd4);
    check_output("swap_ack_valid", {31'd0, out_valid}, 32'd0);

    // Mid-frame reset discards the partial frame
    for (int i = 0; i < 5; i++) apply_stimulus(8'h31 + 8'(i));
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_elems = 0;
    rst = 1'b1;
    check_output("mid_rst_cnt", {24'd0, frame_cnt}, 32'd0);
    check_output("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_output("mid_rst_a", out_a, 32'h0);
    check_output("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    send_frame(8'h0A, 1'b0);
    wait_valid("post_rst_wait");
    check_output("post_rst_a", out_a, 32'h0A0B0C0D);
    check_output("post_rst_b", out_b, 32'h0E0F1011);
    ack_frame();
    check_output("post_rst_cnt", {24'd0, frame_cnt}, 32'd1);

    // 255 more acked frames wrap frame_cnt to 0
    for (int k = 0; k < 255; k++) begin
      send_frame(8'(k), 1'b0);
      wait_valid("wrap_wait");
      ack_frame();
    end
    check_output("wrap_cnt", {24'd0, frame_cnt}, 32'd0);
    check_output("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
